// File: rtl/drp_resp_if.sv
// DRP access bus between a requester and the drp_resp register/PLL model.
interface drp_resp_if;
    logic        DEN;
    logic        DWE;
    logic [4:0]  DADDR;
    logic [15:0] DI;
    logic [15:0] DO;
    logic        DRDY;

    modport master (output DEN, DWE, DADDR, DI, input DO, DRDY);
    modport slave  (input DEN, DWE, DADDR, DI, output DO, DRDY);
endinterface

// File: rtl/drp_resp.sv
// DRP responder: 32x16 register file with fixed-latency DRDY, plus an
// independent PLL lock model and a sticky protocol-violation flag.
module drp_resp #(
    parameter int unsigned RDY_LAT  = 3,
    parameter int unsigned LOCK_CYC = 100
) (
    input  logic      CLK,
    input  logic      RSTX,
    input  logic      RST_PLL,
    drp_resp_if.slave drp,
    output logic      LOCKED,
    output logic      ERR
);
    typedef enum logic [1:0] {IDLE, BUSY, RDY} state_t;

    localparam logic [3:0]  LAT_LAST = 4'(RDY_LAT - 1);
    localparam logic [15:0] LOCK_C   = 16'(LOCK_CYC);

    state_t      state_q, state_d;
    logic [3:0]  lat_q, lat_d;
    logic [4:0]  addr_q, addr_d;
    logic        we_q, we_d;
    logic [15:0] di_q, di_d;
    logic [15:0] do_q, do_d;
    logic        drdy_q, drdy_d;
    logic        err_q, err_d;
    logic [15:0] lock_q, lock_d;
    logic        locked_q, locked_d;
    logic [15:0] mem_q [32];

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        addr_d  = addr_q;
        we_d    = we_q;
        di_d    = di_q;
        drdy_d  = 1'b0;
        do_d    = 16'h0000;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (drp.DEN) begin
                    addr_d = drp.DADDR;
                    we_d   = drp.DWE;
                    di_d   = drp.DI;
                    if (RDY_LAT == 1) begin
                        state_d = RDY;
                        lat_d   = 4'd0;
                    end else begin
                        state_d = BUSY;
                        lat_d   = 4'd1;
                    end
                end
            end
            BUSY: begin
                lat_d = lat_q + 4'd1;
                if (lat_q == LAT_LAST) state_d = RDY;
            end
            RDY: begin
                state_d = IDLE;
                lat_d   = 4'd0;
            end
            default: state_d = IDLE;
        endcase
        // DO/DRDY are registered, so they are computed for the cycle being entered
        if (state_d == RDY) begin
            drdy_d = 1'b1;
            do_d   = we_d ? 16'h0000 : mem_q[addr_d];
        end
        if (drp.DEN && ((state_q != IDLE) || (drp.DWE && !RST_PLL))) err_d = 1'b1;
    end

    always_comb begin
        if (RST_PLL)               lock_d = 16'd0;
        else if (lock_q == LOCK_C) lock_d = lock_q;
        else                       lock_d = lock_q + 16'd1;
        locked_d = (lock_d == LOCK_C);
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state_q  <= IDLE;
            lat_q    <= 4'd0;
            addr_q   <= 5'd0;
            we_q     <= 1'b0;
            di_q     <= 16'h0000;
            do_q     <= 16'h0000;
            drdy_q   <= 1'b0;
            err_q    <= 1'b0;
            lock_q   <= 16'd0;
            locked_q <= 1'b0;
            for (int i = 0; i < 32; i++) mem_q[i] <= 16'h0000;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            di_q     <= di_d;
            do_q     <= do_d;
            drdy_q   <= drdy_d;
            err_q    <= err_d;
            lock_q   <= lock_d;
            locked_q <= locked_d;
            // Write commits on the edge leaving RDY
            if (state_q == RDY && we_q) mem_q[addr_q] <= di_q;
        end
    end

    assign drp.DO   = do_q;
    assign drp.DRDY = drdy_q;
    assign LOCKED   = locked_q;
    assign ERR      = err_q;
endmodule

// File: tb/tb_drp_resp.sv
// Bench for drp_resp: RDY_LAT=3 and RDY_LAT=1 instances, scoreboarded DRDY/DO.
module tb_drp_resp;
    logic CLK = 1'b0;
    logic RSTX;
    logic RST_PLL;
    logic locked3, err3, locked1, err1;

    drp_resp_if if3();
    drp_resp_if if1();

    drp_resp #(.RDY_LAT(3), .LOCK_CYC(100)) dut3 (
        .CLK(CLK), .RSTX(RSTX), .RST_PLL(RST_PLL), .drp(if3), .LOCKED(locked3), .ERR(err3));
    drp_resp #(.RDY_LAT(1), .LOCK_CYC(100)) dut1 (
        .CLK(CLK), .RSTX(RSTX), .RST_PLL(RST_PLL), .drp(if1), .LOCKED(locked1), .ERR(err1));

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;
    exp_t q3[$];
    exp_t q1[$];

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [15:0] di;
        logic [15:0] exp_do;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (if3.DRDY) begin
            if (q3.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut3 unexpected DRDY: got 1 expected 0 (t=%0t)", $time);
            end else begin
                e = q3.pop_front();
                chk("dut3 DRDY cycle", cyc, e.cyc);
                chk("dut3 DO", {16'h0, if3.DO}, {16'h0, e.data});
            end
        end else chk("dut3 DO outside DRDY", {16'h0, if3.DO}, 32'h0);
    end

    always @(negedge CLK) begin
        exp_t e;
        if (if1.DRDY) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1 unexpected DRDY: got 1 expected 0 (t=%0t)", $time);
            end else begin
                e = q1.pop_front();
                chk("dut1 DRDY cycle", cyc, e.cyc);
                chk("dut1 DO", {16'h0, if1.DO}, {16'h0, e.data});
            end
        end else chk("dut1 DO outside DRDY", {16'h0, if1.DO}, 32'h0);
    end

    // Called at a negedge; drives a one-cycle DEN and optionally schedules the DRDY
    task automatic access(input bit b1, input logic we, input logic [4:0] a,
                          input logic [15:0] d, input bit push, input logic [15:0] exp_do);
        exp_t e;
        e.cyc  = cyc + (b1 ? 1 : 3);
        e.data = exp_do;
        if (b1) begin
            if1.DEN = 1'b1; if1.DWE = we; if1.DADDR = a; if1.DI = d;
            if (push) q1.push_back(e);
        end else begin
            if3.DEN = 1'b1; if3.DWE = we; if3.DADDR = a; if3.DI = d;
            if (push) q3.push_back(e);
        end
        @(negedge CLK);
        // DWE left high with DEN low must be ignored
        if1.DEN = 1'b0; if1.DWE = 1'b1;
        if3.DEN = 1'b0; if3.DWE = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic lock_wait(input string name);
        for (int n = 1; n <= 100; n++) begin
            @(posedge CLK);
            #1;
            if (n == 99)  chk({name, " LOCKED before"}, {31'h0, locked3}, 32'h0);
            if (n == 100) chk({name, " LOCKED at 100"}, {31'h0, locked3}, 32'h1);
        end
        @(negedge CLK);
    endtask

    function automatic logic [15:0] sweep_val(input logic [4:0] a);
        return {3'b101, a, 3'b010, ~a};
    endfunction

    initial begin
        RSTX = 1'b0; RST_PLL = 1'b1;
        if3.DEN = 1'b0; if3.DWE = 1'b0; if3.DADDR = 5'd0; if3.DI = 16'h0;
        if1.DEN = 1'b0; if1.DWE = 1'b0; if1.DADDR = 5'd0; if1.DI = 16'h0;
        #2;
        chk("reset DO",     {16'h0, if3.DO}, 32'h0);
        chk("reset DRDY",   {31'h0, if3.DRDY}, 32'h0);
        chk("reset LOCKED", {31'h0, locked3}, 32'h0);
        chk("reset ERR",    {31'h0, err3}, 32'h0);
        chk("reset ERR dut1", {31'h0, err1}, 32'h0);
        idle(3);
        RSTX = 1'b1;
        idle(1);

        tbl[0] = '{1'b1, 5'd5,  16'hA5C3, 16'h0000};
        tbl[1] = '{1'b0, 5'd5,  16'h0000, 16'hA5C3};
        tbl[2] = '{1'b1, 5'd0,  16'h1111, 16'h0000};
        tbl[3] = '{1'b0, 5'd0,  16'hFFFF, 16'h1111};
        tbl[4] = '{1'b1, 5'd31, 16'hBEEF, 16'h0000};
        tbl[5] = '{1'b0, 5'd31, 16'h0000, 16'hBEEF};
        tbl[6] = '{1'b0, 5'd5,  16'h0000, 16'hA5C3};
        tbl[7] = '{1'b1, 5'd5,  16'h0F0F, 16'h0000};
        tbl[8] = '{1'b0, 5'd5,  16'h0000, 16'h0F0F};
        tbl[9] = '{1'b0, 5'd7,  16'h0000, 16'h0000};
        for (int i = 0; i < 10; i++) begin
            access(1'b0, tbl[i].we, tbl[i].addr, tbl[i].di, 1'b1, tbl[i].exp_do);
            idle(3);
            chk($sformatf("tbl[%0d] ERR", i), {31'h0, err3}, 32'h0);
        end

        // DEN while BUSY: ignored write, ERR set, first read completes
        access(1'b0, 1'b0, 5'd5, 16'h0000, 1'b1, 16'h0F0F);
        if3.DEN = 1'b1; if3.DWE = 1'b1; if3.DADDR = 5'd0; if3.DI = 16'hDEAD;
        idle(1);
        if3.DEN = 1'b0;
        chk("busy DEN sets ERR", {31'h0, err3}, 32'h1);
        idle(2);
        access(1'b0, 1'b0, 5'd0, 16'h0000, 1'b1, 16'h1111);
        idle(3);
        chk("ERR sticky", {31'h0, err3}, 32'h1);

        // Reset in the middle of a write
        access(1'b0, 1'b1, 5'd2, 16'h1234, 1'b0, 16'h0000);
        RSTX = 1'b0;
        #1;
        chk("async rst DRDY", {31'h0, if3.DRDY}, 32'h0);
        chk("async rst ERR",  {31'h0, err3}, 32'h0);
        idle(2);
        RSTX = 1'b1;
        chk("post rst ERR",    {31'h0, err3}, 32'h0);
        chk("post rst LOCKED", {31'h0, locked3}, 32'h0);
        idle(1);
        access(1'b0, 1'b0, 5'd2, 16'h0000, 1'b1, 16'h0000);
        idle(3);
        access(1'b0, 1'b0, 5'd5, 16'h0000, 1'b1, 16'h0000);
        idle(3);

        // Lock acquisition, then a one-cycle RST_PLL pulse and re-lock
        RST_PLL = 1'b0;
        lock_wait("first lock");
        chk("no ERR from idle DWE", {31'h0, err3}, 32'h0);
        idle(5);
        chk("LOCKED held", {31'h0, locked3}, 32'h1);
        RST_PLL = 1'b1;
        idle(1);
        chk("LOCKED drop", {31'h0, locked3}, 32'h0);
        RST_PLL = 1'b0;
        lock_wait("relock");

        // Write with RST_PLL low: flagged but committed
        access(1'b0, 1'b1, 5'd31, 16'hFFFF, 1'b1, 16'h0000);
        idle(3);
        chk("pll-low write ERR", {31'h0, err3}, 32'h1);
        access(1'b0, 1'b0, 5'd31, 16'h0000, 1'b1, 16'hFFFF);
        idle(3);

        // Lock after reset release with RST_PLL already low
        RSTX = 1'b0;
        idle(1);
        RSTX = 1'b1;
        chk("rst clears ERR", {31'h0, err3}, 32'h0);
        lock_wait("post-reset lock");

        // RDY_LAT=1 sweep
        RST_PLL = 1'b1;
        idle(1);
        for (int a = 0; a < 32; a++) begin
            access(1'b1, 1'b1, 5'(a), sweep_val(5'(a)), 1'b1, 16'h0000);
            idle(1);
        end
        for (int a = 0; a < 32; a++) begin
            access(1'b1, 1'b0, 5'(a), 16'h0000, 1'b1, sweep_val(5'(a)));
            idle(1);
        end
        chk("dut1 ERR", {31'h0, err1}, 32'h0);

        idle(5);
        chk("dut3 DRDY outstanding", q3.size(), 32'h0);
        chk("dut1 DRDY outstanding", q1.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
